dot_field: RTL
==============

DOT_FIELD -- requirements
Module: dot_field

Interface
REQ-001 Parameter N_DOTS, default 32, number of dots tracked (2..256).
REQ-002 Parameter COORD_W, default 10, coordinate width.
REQ-003 Parameter HIT_RADIUS, default 1, max per-axis distance (pixels) counted as a hit.
REQ-004 Parameter SCORE_W, default 16, score width.
REQ-005 Parameter POINTS_DOT, default 10, score per normal dot.
REQ-006 Parameter POINTS_PELLET, default 50, score per power pellet (macro-dependent).
REQ-007 Parameter PELLET_MASK, default 32'h8000_0009, N_DOTS bits, 1 = dot is a power pellet.
REQ-008 Parameter POWER_FRAMES, default 300, frightened-mode duration in frame_tick units.
REQ-009 Clk  in  1  system clock; all state updates on rising edge.
REQ-010 Reset_n  in  1  reset, asynchronous, active-low.
REQ-011 frame_tick  in  1  one-cycle pulse starting a collision scan.
REQ-012 level_restart  in  1  re-arms all dots for a new level.
REQ-013 pX, pY  in  COORD_W  PacMan position, sampled at scan start.
REQ-014 rd_idx  out  clog2(N_DOTS)  dot-coordinate ROM address.
REQ-015 rd_x, rd_y  in  COORD_W  ROM data, valid one cycle after rd_idx.
REQ-016 eaten  out  N_DOTS  bitmap, 1 = dot consumed.
REQ-017 dots_left  out  clog2(N_DOTS+1)  count of uneaten dots.
REQ-018 score  out  SCORE_W  cumulative score.
REQ-019 dot_eaten  out  1  one-cycle pulse per dot consumed.
REQ-020 level_clear  out  1  one-cycle pulse when last dot consumed.
REQ-021 busy  out  1  high while not IDLE.
REQ-022 power_active  out  1  frightened mode active.

Function
REQ-023 FSM states IDLE, SCAN, DONE; IDLE->SCAN on frame_tick; SCAN->DONE after N_DOTS+1 cycles; DONE->IDLE after one cycle.
REQ-024 pX/pY latched on the IDLE->SCAN edge; later changes do not affect the running scan.
REQ-025 SCAN cycle j (0..N_DOTS-1) drives rd_idx=j; cycle j (1..N_DOTS) compares rd_x/rd_y against index j-1.
REQ-026 Hit = |rd_x-pX| <= HIT_RADIUS and |rd_y-pY| <= HIT_RADIUS, computed in COORD_W+1 bits with no wrap (pX=0 does not match x=1023).
REQ-027 On hit for an uneaten dot, same cycle: set eaten bit, dots_left -1, dot_eaten=1, score += point value; already-eaten dots produce no effect.
REQ-028 Score saturates at 2^SCORE_W-1; never wraps.
REQ-029 In DONE, level_clear pulses once if dots_left==0 and the clear has not already been signalled this level.
REQ-030 frame_tick while busy is ignored (no queueing, no state change).
REQ-031 level_restart: next cycle eaten=0, dots_left=N_DOTS, FSM IDLE, rd_idx=0, power_active=0, clear flag cleared; score retained; aborts any scan without partial updates that cycle.
REQ-032 level_restart and frame_tick in same cycle: restart wins, tick dropped.
REQ-033 rd_idx holds 0 in IDLE and DONE.

Reset
REQ-034 Reset_n low asynchronously forces: IDLE, eaten=0, dots_left=N_DOTS, score=0, rd_idx=0, dot_eaten=0, level_clear=0, power_active=0, power timer=0.
REQ-035 Reset assertion mid-scan discards the scan entirely.

Configuration
REQ-036 Macro DOT_FIELD_POWER_PELLET_EN defined: PELLET_MASK dots score POINTS_PELLET and load power timer with POWER_FRAMES (reload if already active); timer decrements on each frame_tick; power_active = timer!=0.
REQ-037 Macro undefined: all dots score POINTS_DOT, PELLET_MASK ignored, power_active tied 0, no timer logic.

Verification
REQ-038 Reset, pX=90,pY=20, frame_tick -> busy for N_DOTS+2 cycles, eaten[0]=1, dots_left=31, score=10, one dot_eaten pulse.
REQ-039 Repeat tick at same position -> no change to eaten, dots_left, score.
REQ-040 pX=0 with dot at x=1023 (y equal) -> no hit; pX=1022 -> hit.
REQ-041 Eat all 32 dots across scans -> dots_left=0, exactly one level_clear pulse; further ticks no pulse; level_restart -> dots_left=32, score unchanged.
REQ-042 frame_tick mid-scan plus level_restart+frame_tick same cycle -> ignored tick; restart wins, FSM IDLE.
REQ-043 With DOT_FIELD_POWER_PELLET_EN, eat dot 0 -> score+50, power_active for 300 ticks then 0; without macro -> score+10, power_active stays 0.

Source files
------------

// File: rtl/dot_field.sv
// Dot collision/score engine: a frame_tick scans the dot-coordinate ROM against PacMan's position.
// Optional power-pellet scoring and frightened timer are enabled by DOT_FIELD_POWER_PELLET_EN.
module dot_field #(
  parameter int N_DOTS        = 32,
  parameter int COORD_W       = 10,
  parameter int HIT_RADIUS    = 1,
  parameter int SCORE_W       = 16,
  parameter int POINTS_DOT    = 10,
  parameter int POINTS_PELLET = 50,
  parameter logic [N_DOTS-1:0] PELLET_MASK = N_DOTS'(32'h8000_0009),
  parameter int POWER_FRAMES  = 300,
  localparam int IDX_W = $clog2(N_DOTS),
  localparam int CNT_W = $clog2(N_DOTS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               frame_tick_i,
  input  logic               level_restart_i,
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  output logic [IDX_W-1:0]   rd_idx_o,
  input  logic [COORD_W-1:0] rd_x_i,
  input  logic [COORD_W-1:0] rd_y_i,
  output logic [N_DOTS-1:0]  eaten_o,
  output logic [CNT_W-1:0]   dots_left_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               dot_eaten_o,
  output logic               level_clear_o,
  output logic               busy_o,
  output logic               power_active_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [COORD_W:0] RADIUS    = (COORD_W + 1)'(HIT_RADIUS);
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  // Extending both operands by one bit keeps 0 and full-scale far apart instead of wrapping.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    logic [COORD_W:0] ae;
    logic [COORD_W:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    abs_diff = (ae >= be) ? (ae - be) : (be - ae);
  endfunction

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic               busy_q;
  logic [COORD_W-1:0] px_q;
  logic [COORD_W-1:0] py_q;
  logic [N_DOTS-1:0]  eaten_q;
  logic [CNT_W-1:0]   dots_left_q;
  logic [SCORE_W-1:0] score_q;
  logic               dot_eaten_q;
  logic               level_clear_q;
  logic               clear_flag_q;

  logic [IDX_W-1:0]   dot_idx_s;
  logic               hit_s;
  logic [SCORE_W:0]   pts_s;
  logic [SCORE_W:0]   sum_s;
  logic [SCORE_W-1:0] score_d;

  assign dot_idx_s = IDX_W'(cnt_q - CNT_W'(1));

  // Hit detection for the ROM word returned this cycle and the saturated score it would produce.
  always_comb begin
    hit_s = 1'b0;
    if ((state_q == SCAN) && (cnt_q != {CNT_W{1'b0}})) begin
      hit_s = (abs_diff(rd_x_i, px_q) <= RADIUS) && (abs_diff(rd_y_i, py_q) <= RADIUS) &&
              !eaten_q[dot_idx_s];
    end else begin
      hit_s = 1'b0;
    end
`ifdef DOT_FIELD_POWER_PELLET_EN
    if (PELLET_MASK[dot_idx_s]) begin
      pts_s = (SCORE_W + 1)'(POINTS_PELLET);
    end else begin
      pts_s = (SCORE_W + 1)'(POINTS_DOT);
    end
`else
    pts_s = (SCORE_W + 1)'(POINTS_DOT);
`endif
    sum_s = {1'b0, score_q} + pts_s;
    if (sum_s > SCORE_MAX) begin
      score_d = SCORE_MAX[SCORE_W-1:0];
    end else begin
      score_d = sum_s[SCORE_W-1:0];
    end
  end

  // Scan FSM together with the dot bitmap, counters and pulse outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      rd_idx_q      <= {IDX_W{1'b0}};
      busy_q        <= 1'b0;
      px_q          <= {COORD_W{1'b0}};
      py_q          <= {COORD_W{1'b0}};
      eaten_q       <= {N_DOTS{1'b0}};
      dots_left_q   <= CNT_W'(N_DOTS);
      score_q       <= {SCORE_W{1'b0}};
      dot_eaten_q   <= 1'b0;
      level_clear_q <= 1'b0;
      clear_flag_q  <= 1'b0;
    end else if (level_restart_i) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      rd_idx_q      <= {IDX_W{1'b0}};
      busy_q        <= 1'b0;
      eaten_q       <= {N_DOTS{1'b0}};
      dots_left_q   <= CNT_W'(N_DOTS);
      dot_eaten_q   <= 1'b0;
      level_clear_q <= 1'b0;
      clear_flag_q  <= 1'b0;
    end else begin
      dot_eaten_q   <= 1'b0;
      level_clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_tick_i) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            px_q    <= px_i;
            py_q    <= py_i;
          end
          cnt_q    <= {CNT_W{1'b0}};
          rd_idx_q <= {IDX_W{1'b0}};
        end
        SCAN: begin
          if (cnt_q == CNT_W'(N_DOTS)) begin
            state_q <= DONE;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (cnt_q < CNT_W'(N_DOTS - 1)) begin
            rd_idx_q <= IDX_W'(cnt_q + CNT_W'(1));
          end else begin
            rd_idx_q <= {IDX_W{1'b0}};
          end
          if (hit_s) begin
            eaten_q[dot_idx_s] <= 1'b1;
            dots_left_q        <= dots_left_q - CNT_W'(1);
            dot_eaten_q        <= 1'b1;
            score_q            <= score_d;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          rd_idx_q <= {IDX_W{1'b0}};
          if ((dots_left_q == {CNT_W{1'b0}}) && !clear_flag_q) begin
            level_clear_q <= 1'b1;
            clear_flag_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          cnt_q    <= {CNT_W{1'b0}};
          rd_idx_q <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

`ifdef DOT_FIELD_POWER_PELLET_EN
  localparam int TMR_W = $clog2(POWER_FRAMES + 1);

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             power_q;

  // A pellet hit reloads the timer even when it is still running; otherwise ticks count it down.
  always_comb begin
    timer_d = timer_q;
    if (hit_s && PELLET_MASK[dot_idx_s]) begin
      timer_d = TMR_W'(POWER_FRAMES);
    end else if (frame_tick_i && (timer_q != {TMR_W{1'b0}})) begin
      timer_d = timer_q - TMR_W'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Frightened-mode timer and its registered active flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q <= {TMR_W{1'b0}};
      power_q <= 1'b0;
    end else if (level_restart_i) begin
      timer_q <= {TMR_W{1'b0}};
      power_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      power_q <= (timer_d != {TMR_W{1'b0}});
    end
  end

  assign power_active_o = power_q;
`else
  assign power_active_o = 1'b0;
`endif

  assign rd_idx_o      = rd_idx_q;
  assign eaten_o       = eaten_q;
  assign dots_left_o   = dots_left_q;
  assign score_o       = score_q;
  assign dot_eaten_o   = dot_eaten_q;
  assign level_clear_o = level_clear_q;
  assign busy_o        = busy_q;

endmodule
